// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube animation frame loader.
// Address split is {frame[7:0], byte[5:0]}, which is why FRAME_BYTES is fixed at 64.
package led_cube_pkg;

  localparam int          CUBE_ADDR_W         = 14;
  localparam logic [7:0]  FRAME_BYTES         = 8'd64;
  localparam logic [7:0]  MAX_FRAMES          = 8'd150;
  localparam logic [7:0]  NUM_SLOTS           = 8'd5;
  localparam logic [7:0]  SYNC_BYTE           = 8'hA5;
  localparam logic [20:0] TIMEOUT_CYC_DEFAULT = 21'd1_500_000;
  localparam logic [5:0]  LAST_BYTE_IDX       = 6'd63;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_SLOT  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_HDR  = 2'b01,
    ERR_CSUM = 2'b10,
    ERR_TMO  = 2'b11
  } err_code_t;

  // Checksum is a plain mod-256 running sum of the data bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  function automatic logic hdr_count_bad(input logic [7:0] count);
    return (count == 8'd0) || (count > MAX_FRAMES);
  endfunction

endpackage

// File: rtl/led_cube_frame_loader_if.sv
// Byte-stream input and frame-memory write port of the frame loader.
// master = stream source / memory side, slave = the loader itself.
interface led_cube_frame_loader_if;
  import led_cube_pkg::*;

  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   wr_en;
  logic [2:0]             wr_slot;
  logic [CUBE_ADDR_W-1:0] wr_addr;
  logic [7:0]             wr_data;
  logic                   busy;
  logic                   load_done;
  logic                   load_err;
  logic [1:0]             err_code;
  logic [7:0]             frames_loaded;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_slot, wr_addr, wr_data,
    input  busy, load_done, load_err, err_code, frames_loaded
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_slot, wr_addr, wr_data,
    output busy, load_done, load_err, err_code, frames_loaded
  );

endinterface

// File: rtl/led_cube_frame_loader_gap.sv
// Inter-byte gap timer: counts idle cycles while enabled, reports the cycle
// on which the gap would reach LIMIT. A clear in that same cycle suppresses expiry.
module loader_gap_timer #(
  parameter logic [20:0] LIMIT = 21'd1_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [20:0] LAST_CNT = LIMIT - 21'd1;

  logic [20:0] cnt_r;

  // Gap counter; held at zero whenever the timer is not armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 21'd0;
    end else if (clear || !enable) begin
      cnt_r <= 21'd0;
    end else if (cnt_r != LAST_CNT) begin
      cnt_r <= cnt_r + 21'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry decode for the current cycle.
  always_comb begin
    expired = 1'b0;
    if (enable && !clear && (cnt_r == LAST_CNT)) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/led_cube_frame_loader.sv
// Write side of the animation frame store: parses SYNC/slot/count/data/csum
// from a valid/ready byte stream and writes data bytes at {frame, byte}.
module led_cube_frame_loader
  import led_cube_pkg::*;
#(
  parameter logic [20:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic                    clk,
  input logic                    rst_n,
  led_cube_frame_loader_if.slave bus
);

  loader_state_t state_r;
  logic [7:0]    count_r;
  logic [7:0]    frame_idx_r;
  logic [5:0]    byte_idx_r;
  logic [7:0]    sum_r;

  logic          rx_ready_r;
  logic          wr_en_r;
  logic [2:0]    wr_slot_r;
  logic [13:0]   wr_addr_r;
  logic [7:0]    wr_data_r;
  logic          busy_r;
  logic          load_done_r;
  logic          load_err_r;
  err_code_t     err_code_r;
  logic [7:0]    frames_loaded_r;

  logic          accept_s;
  logic          timer_en_s;
  logic          expired_s;
  logic          last_data_s;

  assign accept_s = bus.rx_valid & rx_ready_r;

  // Timer armed only while a packet is being parsed.
  always_comb begin
    timer_en_s  = 1'b0;
    last_data_s = 1'b0;
    case (state_r)
      ST_SLOT, ST_COUNT, ST_DATA, ST_CHECK: timer_en_s = 1'b1;
      default:                              timer_en_s = 1'b0;
    endcase
    if ((frame_idx_r == count_r - 8'd1) && (byte_idx_r == LAST_BYTE_IDX)) begin
      last_data_s = 1'b1;
    end else begin
      last_data_s = 1'b0;
    end
  end

  loader_gap_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // Packet parser FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_HUNT;
      count_r         <= 8'd0;
      frame_idx_r     <= 8'd0;
      byte_idx_r      <= 6'd0;
      sum_r           <= 8'd0;
      rx_ready_r      <= 1'b1;
      wr_en_r         <= 1'b0;
      wr_slot_r       <= 3'd0;
      wr_addr_r       <= 14'd0;
      wr_data_r       <= 8'd0;
      busy_r          <= 1'b0;
      load_done_r     <= 1'b0;
      load_err_r      <= 1'b0;
      err_code_r      <= ERR_NONE;
      frames_loaded_r <= 8'd0;
    end else begin
      wr_en_r     <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          rx_ready_r <= 1'b1;
          if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
            state_r <= ST_SLOT;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_SLOT: begin
          if (accept_s) begin
            wr_slot_r <= bus.rx_data[2:0];
            if (bus.rx_data >= NUM_SLOTS) begin
              state_r    <= ST_ERR;
              load_err_r <= 1'b1;
              err_code_r <= ERR_HDR;
              busy_r     <= 1'b0;
              rx_ready_r <= 1'b0;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_COUNT;
            end
          end else if (expired_s) begin
            state_r    <= ST_ERR;
            load_err_r <= 1'b1;
            err_code_r <= ERR_TMO;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b0;
          end else begin
            state_r <= ST_SLOT;
          end
        end
        ST_COUNT: begin
          if (accept_s) begin
            if (hdr_count_bad(bus.rx_data)) begin
              state_r    <= ST_ERR;
              load_err_r <= 1'b1;
              err_code_r <= ERR_HDR;
              busy_r     <= 1'b0;
              rx_ready_r <= 1'b0;
            end else begin
              count_r     <= bus.rx_data;
              frame_idx_r <= 8'd0;
              byte_idx_r  <= 6'd0;
              sum_r       <= 8'd0;
              state_r     <= ST_DATA;
            end
          end else if (expired_s) begin
            state_r    <= ST_ERR;
            load_err_r <= 1'b1;
            err_code_r <= ERR_TMO;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b0;
          end else begin
            state_r <= ST_COUNT;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            wr_en_r    <= 1'b1;
            wr_data_r  <= bus.rx_data;
            wr_addr_r  <= {frame_idx_r, byte_idx_r};
            sum_r      <= csum_add(sum_r, bus.rx_data);
            byte_idx_r <= byte_idx_r + 6'd1;
            if (byte_idx_r == LAST_BYTE_IDX) begin
              frame_idx_r <= frame_idx_r + 8'd1;
            end else begin
              frame_idx_r <= frame_idx_r;
            end
            if (last_data_s) begin
              state_r <= ST_CHECK;
            end else begin
              state_r <= ST_DATA;
            end
          end else if (expired_s) begin
            state_r    <= ST_ERR;
            load_err_r <= 1'b1;
            err_code_r <= ERR_TMO;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b0;
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_CHECK: begin
          if (accept_s) begin
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b0;
            if (bus.rx_data == sum_r) begin
              state_r         <= ST_DONE;
              load_done_r     <= 1'b1;
              frames_loaded_r <= count_r;
            end else begin
              state_r    <= ST_ERR;
              load_err_r <= 1'b1;
              err_code_r <= ERR_CSUM;
            end
          end else if (expired_s) begin
            state_r    <= ST_ERR;
            load_err_r <= 1'b1;
            err_code_r <= ERR_TMO;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b0;
          end else begin
            state_r <= ST_CHECK;
          end
        end
        ST_DONE, ST_ERR: begin
          rx_ready_r <= 1'b1;
          state_r    <= ST_HUNT;
        end
        default: begin
          rx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_HUNT;
        end
      endcase
    end
  end

  assign bus.rx_ready      = rx_ready_r;
  assign bus.wr_en         = wr_en_r;
  assign bus.wr_slot       = wr_slot_r;
  assign bus.wr_addr       = wr_addr_r;
  assign bus.wr_data       = wr_data_r;
  assign bus.busy          = busy_r;
  assign bus.load_done     = load_done_r;
  assign bus.load_err      = load_err_r;
  assign bus.err_code      = err_code_r;
  assign bus.frames_loaded = frames_loaded_r;

endmodule

// File: tb/tb_led_cube_frame_loader.sv
// Self-checking bench for led_cube_frame_loader: directed header/checksum/timeout
// cases plus random packets checked against a packet-level reference model.
module tb_led_cube_frame_loader;

  localparam logic [20:0] TMO   = 21'd100;
  localparam int          TMO_I = 100;

  typedef struct packed {
    logic [2:0]  slot;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk;
  logic rst_n;
  led_cube_frame_loader_if ifc();

  led_cube_frame_loader #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  logic [7:0] pkt_q[$];
  wr_t        obs_q[$];
  wr_t        exp_q[$];
  int         m_kind;      // 1 = expect load_done, 2 = expect load_err
  logic [1:0] m_code;
  logic [7:0] m_frames;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.wr_en) obs_q.push_back({ifc.wr_slot, ifc.wr_addr, ifc.wr_data});
      if (ifc.load_done) done_cnt++;
      if (ifc.load_err) err_cnt++;
    end
  end

  // Reference: whole-packet interpretation; byte k of the payload lands at address k.
  function automatic void model_pkt();
    int i, n;
    logic [7:0] slot, cnt, s;
    exp_q.delete();
    i = 0;
    while (i < pkt_q.size() && pkt_q[i] != 8'hA5) i++;
    slot = pkt_q[i+1];
    if (slot >= 8'd5) begin m_kind = 2; m_code = 2'b01; return; end
    cnt = pkt_q[i+2];
    if (cnt == 8'd0 || cnt > 8'd150) begin m_kind = 2; m_code = 2'b01; return; end
    n = int'(cnt) * 64;
    s = 8'd0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({slot[2:0], 14'(k), pkt_q[i+3+k]});
      s = s + pkt_q[i+3+k];
    end
    if (pkt_q[i+3+n] == s) begin m_kind = 1; m_frames = cnt; end
    else begin m_kind = 2; m_code = 2'b10; end
  endfunction

  task automatic build_pkt(input logic [7:0] slot, input logic [7:0] cnt, input bit good);
    logic [7:0] s, b;
    pkt_q.push_back(8'hA5);
    pkt_q.push_back(slot);
    if (slot >= 8'd5) return;
    pkt_q.push_back(cnt);
    if (cnt == 8'd0 || cnt > 8'd150) return;
    s = 8'd0;
    for (int k = 0; k < int'(cnt) * 64; k++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
      pkt_q.push_back(b);
      s = s + b;
    end
    pkt_q.push_back(good ? s : s + 8'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   guard;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    guard = 0;
    do begin
      acc = ifc.rx_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 20);
    ifc.rx_valid = 1'b0;
    total++;
    if (!acc) begin bad++; $display("FAIL send_byte accept: ready=0 want=1"); end
  endtask

  task automatic send_range(input int from, input int upto, input int max_gap);
    for (int k = from; k < upto; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      send_byte(pkt_q[k]);
    end
  endtask

  task automatic test_reset();
    total++;
    if (ifc.rx_ready !== 1'b1 || ifc.wr_en !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.load_done !== 1'b0 || ifc.load_err !== 1'b0 || ifc.err_code !== 2'b00 ||
        ifc.frames_loaded !== 8'd0 || ifc.wr_slot !== 3'd0 || ifc.wr_addr !== 14'd0) begin
      bad++;
      $display("FAIL reset_state: ready=%b wr_en=%b busy=%b code=%b frames=%0d want ready=1 others 0",
               ifc.rx_ready, ifc.wr_en, ifc.busy, ifc.err_code, ifc.frames_loaded);
    end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    obs_q.delete(); pkt_q.delete();
    pkt_q = '{8'hA5, 8'h02, 8'h01};
    for (int k = 0; k < 64; k++) pkt_q.push_back(8'(k));
    pkt_q.push_back(8'hE0);
    model_pkt();
    send_range(0, pkt_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (obs_q.size() != 64) begin bad++; $display("FAIL basic_writes: got=%0d want=64", obs_q.size()); end
    else foreach (obs_q[k]) if (obs_q[k] !== exp_q[k]) begin
      bad++; $display("FAIL basic_wr[%0d]: got=%h want=%h", k, obs_q[k], exp_q[k]); break;
    end
    total++;
    if (done_cnt != d0 + 1 || ifc.frames_loaded !== 8'd1) begin
      bad++; $display("FAIL basic_done: dones=%0d frames=%0d want dones=%0d frames=1", done_cnt - d0, ifc.frames_loaded, 1);
    end
  endtask

  task automatic test_frame_wrap();
    int d0 = done_cnt;
    obs_q.delete(); pkt_q.delete();
    pkt_q = '{8'hA5, 8'h00, 8'h02};
    for (int k = 0; k < 128; k++) pkt_q.push_back(8'h01);
    pkt_q.push_back(8'h80);
    model_pkt();
    for (int k = 0; k < pkt_q.size(); k++) begin
      send_byte(pkt_q[k]);
      if (k == 3 + 64) begin
        total++;
        if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 14'h040 || ifc.busy !== 1'b1) begin
          bad++; $display("FAIL wrap_addr: wr_en=%b addr=%h busy=%b want 1 040 1", ifc.wr_en, ifc.wr_addr, ifc.busy);
        end
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (obs_q.size() != exp_q.size() || done_cnt != d0 + 1 || ifc.frames_loaded !== 8'd2 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL wrap_done: writes=%0d dones=%0d frames=%0d want 128 1 2", obs_q.size(), done_cnt - d0, ifc.frames_loaded);
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] hdr[3][$];
    hdr[0] = '{8'hA5, 8'h05};
    hdr[1] = '{8'hA5, 8'h00, 8'h00};
    hdr[2] = '{8'hA5, 8'h00, 8'h97};
    for (int c = 0; c < 3; c++) begin
      int e0 = err_cnt;
      obs_q.delete();
      pkt_q = hdr[c];
      model_pkt();
      send_range(0, pkt_q.size(), 2);
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (err_cnt != e0 + 1 || ifc.err_code !== 2'b01 || obs_q.size() != 0 || m_code != 2'b01) begin
        bad++; $display("FAIL bad_header[%0d]: errs=%0d code=%b writes=%0d want 1 01 0", c, err_cnt - e0, ifc.err_code, obs_q.size());
      end
    end
  endtask

  task automatic test_bad_csum();
    int e0 = err_cnt;
    logic [7:0] f0 = m_frames;
    obs_q.delete(); pkt_q.delete();
    build_pkt(8'd4, 8'd1, 1'b0);
    model_pkt();
    send_range(0, pkt_q.size(), 1);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (obs_q.size() != 64) begin bad++; $display("FAIL csum_writes: got=%0d want=64", obs_q.size()); end
    else foreach (obs_q[k]) if (obs_q[k] !== exp_q[k]) begin
      bad++; $display("FAIL csum_wr[%0d]: got=%h want=%h", k, obs_q[k], exp_q[k]); break;
    end
    total++;
    if (err_cnt != e0 + 1 || ifc.err_code !== 2'b10 || ifc.frames_loaded !== f0) begin
      bad++; $display("FAIL csum_err: errs=%0d code=%b frames=%0d want 1 10 %0d", err_cnt - e0, ifc.err_code, ifc.frames_loaded, f0);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    obs_q.delete(); pkt_q.delete();
    build_pkt(8'd1, 8'd1, 1'b1);
    send_range(0, 13, 0);
    repeat (TMO_I - 1) begin @(posedge clk); #1; end
    total++;
    if (ifc.load_err !== 1'b0 || err_cnt != e0) begin
      bad++; $display("FAIL tmo_early: load_err=%b want 0", ifc.load_err);
    end
    @(posedge clk); #1;
    total++;
    if (ifc.load_err !== 1'b1 || ifc.err_code !== 2'b11 || ifc.busy !== 1'b0 || obs_q.size() != 10) begin
      bad++; $display("FAIL tmo_err: load_err=%b code=%b busy=%b writes=%0d want 1 11 0 10",
                      ifc.load_err, ifc.err_code, ifc.busy, obs_q.size());
    end
    m_code = 2'b11;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_expiry_byte();
    int e0 = err_cnt;
    int d0 = done_cnt;
    obs_q.delete(); pkt_q.delete();
    build_pkt(8'd1, 8'd1, 1'b1);
    model_pkt();
    send_range(0, 13, 0);
    repeat (TMO_I - 1) begin @(posedge clk); #1; end
    send_range(13, pkt_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (err_cnt != e0 || done_cnt != d0 + 1 || obs_q.size() != 64 || ifc.err_code !== m_code) begin
      bad++; $display("FAIL expiry_byte: errs=%0d dones=%0d writes=%0d want 0 1 64", err_cnt - e0, done_cnt - d0, obs_q.size());
    end
  endtask

  task automatic test_reset_mid_data();
    pkt_q.delete();
    build_pkt(8'd3, 8'd2, 1'b1);
    send_range(0, 23, 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ifc.wr_en !== 1'b0 || ifc.busy !== 1'b0 || ifc.rx_ready !== 1'b1 || ifc.wr_addr !== 14'd0 ||
        ifc.wr_data !== 8'd0 || ifc.wr_slot !== 3'd0 || ifc.err_code !== 2'b00 || ifc.frames_loaded !== 8'd0) begin
      bad++; $display("FAIL reset_mid: wr_en=%b busy=%b ready=%b addr=%h slot=%0d code=%b want 0 0 1 0 0 00",
                      ifc.wr_en, ifc.busy, ifc.rx_ready, ifc.wr_addr, ifc.wr_slot, ifc.err_code);
    end
    m_code = 2'b00; m_frames = 8'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_leading_junk();
    int d0 = done_cnt;
    obs_q.delete(); pkt_q.delete();
    pkt_q.push_back(8'h00);
    pkt_q.push_back(8'hFF);
    build_pkt(8'd0, 8'd1, 1'b1);
    model_pkt();
    send_range(0, pkt_q.size(), 2);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (done_cnt != d0 + 1 || obs_q.size() != 64 || ifc.frames_loaded !== m_frames) begin
      bad++; $display("FAIL junk_done: dones=%0d writes=%0d frames=%0d want 1 64 %0d", done_cnt - d0, obs_q.size(), ifc.frames_loaded, m_frames);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      int d0 = done_cnt;
      int e0 = err_cnt;
      logic [7:0] slot, cnt;
      slot = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(5, 7)) : 8'($urandom_range(0, 4));
      case ($urandom_range(0, 7))
        0:       cnt = 8'd0;
        1:       cnt = 8'($urandom_range(151, 255));
        default: cnt = 8'($urandom_range(1, 3));
      endcase
      obs_q.delete(); pkt_q.delete();
      build_pkt(slot, cnt, $urandom_range(0, 2) != 0);
      model_pkt();
      send_range(0, pkt_q.size(), 3);
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand[%0d]_writes: got=%0d want=%0d", p, obs_q.size(), exp_q.size());
      end else foreach (obs_q[k]) if (obs_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL rand[%0d]_wr[%0d]: got=%h want=%h", p, k, obs_q[k], exp_q[k]); break;
      end
      total++;
      if (done_cnt - d0 != (m_kind == 1 ? 1 : 0) || err_cnt - e0 != (m_kind == 2 ? 1 : 0) ||
          ifc.err_code !== m_code || ifc.frames_loaded !== m_frames) begin
        bad++; $display("FAIL rand[%0d]_status: dones=%0d errs=%0d code=%b frames=%0d want kind=%0d code=%b frames=%0d",
                        p, done_cnt - d0, err_cnt - e0, ifc.err_code, ifc.frames_loaded, m_kind, m_code, m_frames);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.rx_data  = 8'd0;
    ifc.rx_valid = 1'b0;
    m_code = 2'b00; m_frames = 8'd0; m_kind = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_frame_wrap();
    test_bad_header();
    test_bad_csum();
    test_timeout();
    test_expiry_byte();
    test_reset_mid_data();
    test_leading_junk();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
